// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: queues DRP {addr, mask, data} entries, then read-modify-writes them into a PLL held in reset and waits for lock.
// Define PLL_DRP_CTRL_TIMEOUT_EN to bound every DRDY/LOCKED wait by TIMEOUT cycles and raise a sticky ERROR.
module pll_drp_ctrl #(
    parameter int DEPTH    = 8,
    parameter int RST_HOLD = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        CFG_VALID,
    output logic        CFG_READY,
    input  logic [6:0]  CFG_ADDR,
    input  logic [15:0] CFG_MASK,
    input  logic [15:0] CFG_DATA,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        PLL_RST,
    input  logic        LOCKED
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ASSERT    = 3'd1;
    localparam logic [2:0] S_RD        = 3'd2;
    localparam logic [2:0] S_WAIT_RD   = 3'd3;
    localparam logic [2:0] S_WR        = 3'd4;
    localparam logic [2:0] S_WAIT_WR   = 3'd5;
    localparam logic [2:0] S_HOLD      = 3'd6;
    localparam logic [2:0] S_WAIT_LOCK = 3'd7;

    logic [6:0]    addr_q [DEPTH];
    logic [15:0]   mask_q [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [15:0]   di_q, di_d, new_w;
    logic          rst_q, rst_d, done_q, done_d;
    logic          push, pop, go, clr, tmo;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    function automatic logic is_wait(input logic [2:0] s);
        return s == S_WAIT_RD || s == S_WAIT_WR || s == S_WAIT_LOCK;
    endfunction

    assign CFG_READY = !RST && state_q == S_IDLE && cnt_q != CW'(DEPTH);
    assign push      = CFG_VALID && CFG_READY;
    assign go        = state_q == S_IDLE && START && cnt_q != '0;
    assign pop       = state_q == S_WAIT_WR && DRDY;
    assign new_w     = (DO & mask_q[rp_q]) | (data_q[rp_q] & ~mask_q[rp_q]);

    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        case (state_q)
            S_IDLE:      if (go) begin state_d = S_ASSERT; rst_d = 1'b1; end
            S_ASSERT:    state_d = S_RD;
            S_RD:        state_d = S_WAIT_RD;
            S_WAIT_RD:   if (DRDY) state_d = S_WR;
            S_WR:        state_d = S_WAIT_WR;
            S_WAIT_WR:   if (DRDY) state_d = cnt_q > CW'(1) ? S_RD : S_HOLD;
            S_HOLD:      if (hcnt_q == HW'(RST_HOLD - 1)) begin state_d = S_WAIT_LOCK; rst_d = 1'b0; end
            S_WAIT_LOCK: if (LOCKED) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (tmo) begin
            state_d = S_IDLE;
            rst_d   = 1'b0;
        end
    end

    // Whatever ends a sequence also flushes the queue, so an aborted run leaves nothing behind.
    assign clr     = state_q != S_IDLE && state_d == S_IDLE;
    assign wp_d    = clr ? '0 : (push ? inc(wp_q) : wp_q);
    assign rp_d    = clr ? '0 : (pop ? inc(rp_q) : rp_q);
    assign cnt_d   = clr ? '0 : cnt_q + CW'(push) - CW'(pop);
    assign hcnt_d  = state_q == S_HOLD ? hcnt_q + HW'(1) : '0;
    assign daddr_d = state_d == S_RD ? addr_q[rp_d] : daddr_q;
    assign di_d    = state_d == S_WR ? new_w : di_q;
    assign done_d  = state_q == S_WAIT_LOCK && LOCKED;

    always_ff @(posedge DCLK)
        if (push) begin
            addr_q[wp_q] <= CFG_ADDR;
            mask_q[wp_q] <= CFG_MASK;
            data_q[wp_q] <= CFG_DATA;
        end

    always_ff @(posedge DCLK or posedge RST)
        if (RST) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            daddr_q <= '0;
            di_q    <= '0;
            rst_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end

`ifdef PLL_DRP_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    assign tmo    = is_wait(state_q) && !(state_q == S_WAIT_LOCK ? LOCKED : DRDY) && tcnt_q == TW'(TIMEOUT - 1);
    assign tcnt_d = is_wait(state_d) && state_d == state_q ? tcnt_q + TW'(1) : '0;
    assign err_d  = go ? 1'b0 : (tmo ? 1'b1 : err_q);
    assign ERROR  = err_q;

    always_ff @(posedge DCLK or posedge RST)
        if (RST) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT != 0 && is_wait(state_q);
    assign tmo            = 1'b0;
    assign ERROR          = 1'b0;
`endif

    assign BUSY    = state_q != S_IDLE;
    assign DONE    = done_q;
    assign DEN     = state_q == S_RD || state_q == S_WR;
    assign DWE     = state_q == S_WR;
    assign DADDR   = daddr_q;
    assign DI      = di_q;
    assign PLL_RST = RST || rst_q;
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb_pll_drp_ctrl: directed vector table plus hand sequences against a small DRP/PLL responder model.
module tb_pll_drp_ctrl;
    logic        DCLK = 1'b0, RST = 1'b1;
    logic        CFG_VALID = 1'b0, START = 1'b0;
    logic [6:0]  CFG_ADDR = '0;
    logic [15:0] CFG_MASK = '0, CFG_DATA = '0;
    logic        CFG_READY, BUSY, DONE, ERROR, DEN, DWE, PLL_RST, LOCKED;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO = '0;
    logic        DRDY = 1'b0;
    int          passed = 0, total = 0, cyc = 0;

`ifdef PLL_DRP_CTRL_TIMEOUT_EN
    localparam int LHOLD = 12;
`else
    localparam int LHOLD = 50;
`endif

    pll_drp_ctrl #(.DEPTH(8), .RST_HOLD(4), .TIMEOUT(16)) dut (
        .DCLK(DCLK), .RST(RST), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .DADDR(DADDR), .DEN(DEN), .DWE(DWE),
        .DI(DI), .DO(DO), .DRDY(DRDY), .PLL_RST(PLL_RST), .LOCKED(LOCKED)
    );

    always #5 DCLK = ~DCLK;
    always @(posedge DCLK) cyc <= cyc + 1;

    // PLL responder: DRDY one cycle after each DEN, reads return init_val, writes are logged.
    logic [15:0] init_val [128];
    logic        drdy_en = 1'b1, lock_en = 1'b1, den_prev = 1'b0;
    int          den_adj = 0, den_cnt = 0;
    logic [6:0]  rd_log[$], wr_alog[$];
    logic [15:0] wr_dlog[$];
    assign LOCKED = lock_en && !PLL_RST;

    always @(posedge DCLK) begin
        DRDY     <= 1'b0;
        den_prev <= DEN;
        if (DEN && den_prev) den_adj <= den_adj + 1;
        if (DEN) begin
            den_cnt <= den_cnt + 1;
            DRDY    <= drdy_en;
            if (DWE) begin
                wr_alog.push_back(DADDR);
                wr_dlog.push_back(DI);
            end else begin
                DO <= init_val[DADDR];
                rd_log.push_back(DADDR);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        @(negedge DCLK);
        CFG_VALID = 1'b1; CFG_ADDR = a; CFG_MASK = m; CFG_DATA = d;
        @(negedge DCLK);
        CFG_VALID = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge DCLK);
        START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
        t0 = cyc;
    endtask

    task automatic run_wait(input int t0, output int lat, output int rc, output logic ok);
        rc = 0; ok = 1'b0; lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (DONE) begin ok = 1'b1; lat = cyc - t0; break; end
            if (PLL_RST) rc++;
            @(negedge DCLK);
        end
    endtask

    typedef struct {
        logic [6:0]  a;
        logic [15:0] m, d, old, exp;
    } vec_t;

    vec_t v[7];
    int   t0, lat, rc, base, base_r, adj0, dc0, bad, n, cnt, r;
    logic ok, seen;

    initial begin
        v[0] = '{7'h08, 16'hF000, 16'h0145, 16'hA3C2, 16'hA145};
        v[1] = '{7'h10, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234};
        v[2] = '{7'h11, 16'hFFFF, 16'h1234, 16'h5A5A, 16'h5A5A};
        v[3] = '{7'h7F, 16'h00FF, 16'hABCD, 16'h1234, 16'hAB34};
        v[4] = '{7'h00, 16'h0F0F, 16'h0000, 16'hFFFF, 16'h0F0F};
        v[5] = '{7'h4E, 16'hAAAA, 16'h5555, 16'hFFFF, 16'hFFFF};
        v[6] = '{7'h22, 16'h5555, 16'h0000, 16'h3C3C, 16'h1414};
        for (int i = 0; i < 128; i++) init_val[i] = 16'(i * 3);
        for (int i = 0; i < 7; i++) init_val[v[i].a] = v[i].old;
        init_val[7'h40] = 16'h1234;

        // reset state
        repeat (2) @(negedge DCLK);
        chk("rst_ready", CFG_READY, 0);
        chk("rst_pllrst", PLL_RST, 1);
        chk("rst_busy_done", {BUSY, DONE, ERROR}, 0);
        chk("rst_den_dwe", {DEN, DWE}, 0);
        chk("rst_daddr_di", {DADDR, DI}, 0);
        RST = 1'b0;
        @(negedge DCLK);
        chk("post_rst_ready", CFG_READY, 1);
        chk("post_rst_pllrst", PLL_RST, 0);

        // single-entry RMW vectors
        for (int i = 0; i < 7; i++) begin
            base = wr_dlog.size();
            push_entry(v[i].a, v[i].m, v[i].d);
            pulse_start(t0);
            run_wait(t0, lat, rc, ok);
            chk($sformatf("vec%0d_done", i), ok, 1);
            chk($sformatf("vec%0d_di", i), wr_dlog[base], v[i].exp);
            chk($sformatf("vec%0d_daddr", i), wr_alog[base], v[i].a);
            chk($sformatf("vec%0d_latency", i), lat, 10);
            chk($sformatf("vec%0d_pllrst_cycles", i), rc, 9);
            chk($sformatf("vec%0d_busy_at_done", i), BUSY, 0);
        end

        // full queue
        base_r = rd_log.size(); base = wr_dlog.size(); adj0 = den_adj;
        for (int i = 0; i < 8; i++) push_entry(7'(7'h30 + i), 16'h0000, 16'(16'h1000 + i));
        chk("full_ready_low", CFG_READY, 0);
        @(negedge DCLK);
        CFG_VALID = 1'b1; CFG_ADDR = 7'h55;
        @(negedge DCLK);
        chk("ninth_not_ready", CFG_READY, 0);
        CFG_VALID = 1'b0;
        pulse_start(t0);
        run_wait(t0, lat, rc, ok);
        chk("full_done", ok, 1);
        chk("full_latency", lat, 38);
        chk("full_reads", rd_log.size() - base_r, 8);
        chk("full_writes", wr_dlog.size() - base, 8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (rd_log[base_r + i] != 7'(7'h30 + i) || wr_alog[base + i] != 7'(7'h30 + i) || wr_dlog[base + i] != 16'(16'h1000 + i)) bad++;
        chk("full_order", bad, 0);
        chk("den_not_adjacent", den_adj - adj0, 0);

        // START with empty queue is ignored
        dc0 = den_cnt; seen = 1'b0;
        pulse_start(t0);
        repeat (5) begin
            if (BUSY) seen = 1'b1;
            @(negedge DCLK);
        end
        chk("empty_start_busy", seen, 0);
        chk("empty_start_den", den_cnt - dc0, 0);

        // START during WAIT_WR and CFG_VALID while busy
        base = wr_dlog.size();
        push_entry(7'h40, 16'hFF00, 16'h00AA);
        pulse_start(t0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (DEN && DWE) begin seen = 1'b1; break; end
            @(negedge DCLK);
        end
        chk("wr_found", seen, 1);
        CFG_VALID = 1'b1; CFG_ADDR = 7'h41;
        #1 chk("busy_ready_low", CFG_READY, 0);
        @(negedge DCLK);
        START = 1'b1;
        @(negedge DCLK);
        START = 1'b0; CFG_VALID = 1'b0;
        run_wait(t0, lat, rc, ok);
        chk("midstart_latency", lat, 10);
        chk("midstart_di", wr_dlog[base], 16'h12AA);
        dc0 = den_cnt; seen = 1'b0;
        repeat (4) begin
            @(negedge DCLK);
            if (BUSY) seen = 1'b1;
        end
        chk("midstart_no_rerun", {seen, 8'(den_cnt - dc0)}, 0);

        // asynchronous reset during WAIT_RD of entry 2 of 3
        for (int i = 0; i < 3; i++) push_entry(7'(7'h50 + i), 16'h0000, 16'h0000);
        pulse_start(t0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (DEN && !DWE) n++;
            if (n == 2) break;
            @(negedge DCLK);
        end
        chk("second_read_found", n, 2);
        @(negedge DCLK);
        RST = 1'b1;
        #1;
        chk("midrst_den_dwe", {DEN, DWE}, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_pllrst", PLL_RST, 1);
        @(negedge DCLK);
        RST = 1'b0;
        @(negedge DCLK);
        chk("midrst_ready", CFG_READY, 1);
        seen = 1'b0; dc0 = den_cnt;
        pulse_start(t0);
        repeat (5) begin
            if (BUSY) seen = 1'b1;
            @(negedge DCLK);
        end
        chk("midrst_queue_empty", {seen, 8'(den_cnt - dc0)}, 0);

        // long lock wait
        lock_en = 1'b0;
        push_entry(7'h60, 16'h0000, 16'h0060);
        pulse_start(t0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!PLL_RST) begin seen = 1'b1; break; end
            @(negedge DCLK);
        end
        chk("lock_wait_entered", seen, 1);
        cnt = 0;
        repeat (LHOLD) begin
            if (!BUSY || DONE) cnt++;
            @(negedge DCLK);
        end
        chk("lock_wait_busy", cnt, 0);
        lock_en = 1'b1;
        cnt = 0;
        repeat (6) begin
            if (DONE) cnt++;
            @(negedge DCLK);
        end
        chk("lock_done_once", cnt, 1);

`ifdef PLL_DRP_CTRL_TIMEOUT_EN
        drdy_en = 1'b0;
        push_entry(7'h70, 16'h0000, 16'h0070);
        pulse_start(t0);
        r = -1;
        for (int i = 0; i < 20; i++) begin
            if (DEN) begin r = cyc; break; end
            @(negedge DCLK);
        end
        seen = 1'b0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (DONE) seen = 1'b1;
            if (ERROR) begin lat = cyc - r - 1; break; end
            @(negedge DCLK);
        end
        chk("tmo_latency", lat, 16);
        chk("tmo_pllrst_busy", {PLL_RST, BUSY}, 0);
        chk("tmo_no_done", seen, 0);
        drdy_en = 1'b1;
        push_entry(7'h71, 16'h0000, 16'h0071);
        chk("tmo_error_sticky", ERROR, 1);
        pulse_start(t0);
        chk("tmo_error_cleared", ERROR, 0);
        run_wait(t0, lat, rc, ok);
        chk("tmo_recovery_done", ok, 1);
`endif
        chk("error_final", ERROR, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
